store_narrower: RTL and testbench

Store-path narrowing unit: the write-side counterpart of immediate/load sign extension. It accepts a 32-bit register value with a store size and byte address. It then drives one or two writes to a 16-bit-wide data memory port with byte enables, and reports whether the value survived narrowing. The value survived if sign-extending the stored field reproduces the original word. It sits between the execute stage and data memory, one store in flight at a time.

---
 rtl/store_narrower_pkg.sv | 29 ++
 rtl/store_narrower_if.sv | 30 +++
 rtl/store_narrower_narrow_fit_check.sv | 18 +
 rtl/store_narrower.sv | 123 ++++++++++++
 tb/tb_store_narrower.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/store_narrower_pkg.sv
// Shared definitions for the store narrowing path: size codes, FSM states
// and the alignment rule used when a store is accepted.
package store_narrower_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WR_LO = 2'b01,
        WR_HI = 2'b10,
        RESP  = 2'b11
    } state_t;

    // True when the store cannot be performed: illegal size or misaligned address.
    function automatic logic store_rejected(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_narrower_if.sv
// Request and memory-port bundle of the store narrower.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a memory write transfers on a rising edge where mem_we && mem_ack.
interface store_narrower_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic [1:0]        req_size;
    logic              mem_we;
    logic [ADDR_W-2:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [1:0]        mem_be;
    logic              mem_ack;
    logic              done;
    logic              ovf;
    logic              err;

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_ack,
        input  req_ready, mem_we, mem_addr, mem_wdata, mem_be, done, ovf, err
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_ack,
        output req_ready, mem_we, mem_addr, mem_wdata, mem_be, done, ovf, err
    );
endinterface

// File: rtl/store_narrower_narrow_fit_check.sv
// Combinational check that a 32-bit value survives narrowing to the given
// store size, i.e. sign-extending the stored field reproduces the word.
module narrow_fit_check
    import store_narrower_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  size,
    output logic        fits
);
    always_comb begin
        fits = 1'b1;
        case (size)
            SZ_BYTE: fits = (data[31:7] == {25{data[7]}});
            SZ_HALF: fits = (data[31:15] == {17{data[15]}});
            default: fits = 1'b1;
        endcase
    end
endmodule

// File: rtl/store_narrower.sv
// Store narrowing unit: steers a 32-bit register value onto a 16-bit memory
// port as one or two byte-enabled writes and reports narrowing overflow.
module store_narrower
    import store_narrower_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    store_narrower_if.slave     bus,
    output state_t              state_dbg
);
    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [1:0]        size_q;
    logic              ovf_q;
    logic              err_q;

    logic              accept;
    logic              rejected;
    logic              fits;
    logic [ADDR_W-2:0] lo_addr;
    logic [ADDR_W-2:0] hi_addr;

    logic              mem_we;
    logic [ADDR_W-2:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [1:0]        mem_be;
    logic              done;
    logic              ovf;
    logic              err;

    localparam logic [ADDR_W-2:0] HALF_STEP = {{(ADDR_W-2){1'b0}}, 1'b1};

    narrow_fit_check u_fit (
        .data (bus.req_data),
        .size (bus.req_size),
        .fits (fits)
    );

    // Ready drops with rst so nothing is accepted on the release edge race.
    assign bus.req_ready = (state == IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign rejected      = store_rejected(bus.req_size, bus.req_addr[1:0]);
    assign lo_addr       = addr_q[ADDR_W-1:1];
    assign hi_addr       = lo_addr + HALF_STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
            data_q <= '0;
            size_q <= SZ_BYTE;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                addr_q <= bus.req_addr;
                data_q <= bus.req_data;
                size_q <= bus.req_size;
                err_q  <= rejected;
                ovf_q  <= !fits && !rejected;
            end
        end
    end

    // Memory outputs decode straight from the state register, so an async
    // reset drops mem_we immediately and idle cycles drive zeros.
    always_comb begin
        state_n   = state;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = 2'b00;
        done      = 1'b0;
        ovf       = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_n = rejected ? RESP : WR_LO;
            end
            WR_LO: begin
                mem_we   = 1'b1;
                mem_addr = lo_addr;
                if (size_q == SZ_BYTE) begin
                    mem_wdata = {data_q[7:0], data_q[7:0]};
                    mem_be    = addr_q[0] ? 2'b10 : 2'b01;
                end else begin
                    mem_wdata = data_q[15:0];
                    mem_be    = 2'b11;
                end
                if (bus.mem_ack) state_n = (size_q == SZ_WORD) ? WR_HI : RESP;
            end
            WR_HI: begin
                mem_we    = 1'b1;
                mem_addr  = hi_addr;
                mem_wdata = data_q[31:16];
                mem_be    = 2'b11;
                if (bus.mem_ack) state_n = RESP;
            end
            RESP: begin
                done    = 1'b1;
                ovf     = ovf_q;
                err     = err_q;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_be    = mem_be;
    assign bus.done      = done;
    assign bus.ovf       = ovf;
    assign bus.err       = err;
    assign state_dbg     = state;

endmodule

// File: tb/tb_store_narrower.sv
// Directed bench for store_narrower: expected writes and responses are queued
// by the driver and consumed by independent memory and response monitors.
module tb_store_narrower;
    import store_narrower_pkg::*;

    logic   clk;
    logic   rst;
    state_t state_dbg;
    int     cyc;
    int     total;
    int     bad;
    int     ack_wait;
    int     wcnt;

    logic [32:0] exp_w_q[$];   // {mem_addr, mem_wdata, mem_be}
    logic [33:0] exp_r_q[$];   // {done cycle, ovf, err}

    store_narrower_if #(.ADDR_W(16)) bus ();

    store_narrower #(.ADDR_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory model and write monitor ----------------
    initial begin
        bus.mem_ack = 1'b0;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_we) begin
                bus.mem_ack = (wcnt >= ack_wait);
                check("write_expected", 64'(exp_w_q.size() != 0), 64'd1);
                if (exp_w_q.size() != 0) begin
                    check("write_beat", 64'({bus.mem_addr, bus.mem_wdata, bus.mem_be}), 64'(exp_w_q[0]));
                    if (bus.mem_ack) void'(exp_w_q.pop_front());
                end
                if (bus.mem_ack) wcnt = 0;
                else wcnt++;
            end else begin
                // Ack left high while idle when zero-wait: the DUT must ignore it.
                bus.mem_ack = (ack_wait == 0);
                wcnt = 0;
                check("idle_bus_zero", 64'({bus.mem_addr, bus.mem_wdata, bus.mem_be}), 64'd0);
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (bus.done) begin
                check("done_expected", 64'(exp_r_q.size() != 0), 64'd1);
                if (exp_r_q.size() != 0) begin
                    e = exp_r_q.pop_front();
                    check("done_cycle", 64'(cyc), 64'(e[33:2]));
                    check("resp_ovf", 64'(bus.ovf), 64'(e[1]));
                    check("resp_err", 64'(bus.err), 64'(e[0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_w(input logic [14:0] a, input logic [15:0] d, input logic [1:0] be);
        exp_w_q.push_back({a, d, be});
    endtask

    task automatic do_store(input logic [15:0] addr, input logic [31:0] data, input logic [1:0] size,
                            input int lat, input logic exp_ovf, input logic exp_err);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_req", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_data  = data;
        bus.req_size  = size;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_data  = 32'h5A5A_5A5A;
        bus.req_addr  = 16'hFFFF;
        exp_r_q.push_back({32'(cyc + lat - 1), exp_ovf, exp_err});
        n = 0;
        while (exp_r_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("resp_timeout", 64'(exp_r_q.size()), 64'd0);
        check("writes_left", 64'(exp_w_q.size()), 64'd0);
        exp_r_q.delete();
        exp_w_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        total = 0;
        bad = 0;
        cyc = 0;
        ack_wait = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.req_size  = SZ_BYTE;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(bus.req_ready), 64'd0);
        check("rst_outputs", 64'({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be,
                                  bus.done, bus.ovf, bus.err}), 64'd0);
        check("rst_state", 64'(state_dbg), 64'(IDLE));
        rst = 1'b0;
        #1;
        check("ready_after_rst", 64'(bus.req_ready), 64'd1);

        // Zero-wait byte and half stores.
        ack_wait = 0;
        push_w(15'h0002, 16'h8080, 2'b10);
        do_store(16'h0005, 32'hFFFF_FF80, SZ_BYTE, 2, 1'b0, 1'b0);
        push_w(15'h0008, 16'h2345, 2'b11);
        do_store(16'h0010, 32'h0001_2345, SZ_HALF, 2, 1'b1, 1'b0);
        push_w(15'h0002, 16'h7F7F, 2'b01);
        do_store(16'h0004, 32'h0000_007F, SZ_BYTE, 2, 1'b0, 1'b0);
        push_w(15'h0003, 16'h8080, 2'b10);
        do_store(16'h0007, 32'h0000_0080, SZ_BYTE, 2, 1'b1, 1'b0);
        push_w(15'h0001, 16'h8000, 2'b11);
        do_store(16'h0002, 32'hFFFF_8000, SZ_HALF, 2, 1'b0, 1'b0);
        push_w(15'h0001, 16'h8000, 2'b11);
        do_store(16'h0002, 32'h0000_8000, SZ_HALF, 2, 1'b1, 1'b0);

        // Word store with two wait cycles per beat.
        ack_wait = 2;
        push_w(15'h0010, 16'hBEEF, 2'b11);
        push_w(15'h0011, 16'hDEAD, 2'b11);
        do_store(16'h0020, 32'hDEAD_BEEF, SZ_WORD, 7, 1'b0, 1'b0);

        // Rejected requests: no writes, one-cycle response, ovf forced low.
        ack_wait = 0;
        do_store(16'h0003, 32'h7FFF_FFFF, SZ_HALF, 1, 1'b0, 1'b1);
        do_store(16'h0002, 32'h1234_5678, SZ_WORD, 1, 1'b0, 1'b1);
        do_store(16'h0000, 32'h8000_0000, SZ_ILL,  1, 1'b0, 1'b1);

        // Word at the top of the address space.
        push_w(15'h7FFE, 16'h5678, 2'b11);
        push_w(15'h7FFF, 16'h1234, 2'b11);
        do_store(16'hFFFC, 32'h1234_5678, SZ_WORD, 3, 1'b0, 1'b0);

        // Reset while the high beat is waiting for ack.
        ack_wait = 4;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'h0040;
        bus.req_data  = 32'hAAAA_5555;
        bus.req_size  = SZ_WORD;
        push_w(15'h0020, 16'h5555, 2'b11);
        push_w(15'h0021, 16'hAAAA, 2'b11);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (!(bus.mem_we && bus.mem_addr == 15'h0021) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("reached_wr_hi", 64'(bus.mem_we && bus.mem_addr == 15'h0021), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_abort_we", 64'(bus.mem_we), 64'd0);
        check("rst_abort_ready", 64'(bus.req_ready), 64'd0);
        exp_w_q.delete();
        exp_r_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_abort", 64'(bus.req_ready), 64'd1);
        repeat (3) @(negedge clk);

        ack_wait = 0;
        push_w(15'h0000, 16'h1212, 2'b10);
        do_store(16'h0001, 32'h0000_0012, SZ_BYTE, 2, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
